decode_cycle: RTL and testbench

Instruction Decode stage of the 5-stage RV32I pipeline. Consumes the IF/ID register contents, reads the 32×32 register file, generates the immediate and control word, and registers everything into the ID/EX pipeline register. Detects load-use hazards against the instruction currently in ID/EX and drives the stall and PC-enable signals back to the fetch stage. Also inserts bubbles on a taken branch or jump signalled from Execute.

---
 rtl/rv32i_pkg.sv | 59 +++++
 rtl/register_file.sv | 40 ++++
 rtl/decode_cycle.sv | 221 ++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: opcodes, ALU/writeback encodings
// and the ID/EX pipeline bundle.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      jal;
    logic      jalr;
    logic      alu_src;
    alu_ctrl_e alu_ctrl;
    wb_sel_e   wb_sel;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] pc4;
  } id_ex_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write: 1'b0, mem_read: 1'b0,
    mem_write: 1'b0, branch: 1'b0,
    jal: 1'b0, jalr: 1'b0, alu_src: 1'b0,
    alu_ctrl: ALU_ADD, wb_sel: WB_ALU
  };

endpackage

// File: rtl/register_file.sv
// 32x32 register file, two read ports, one write port,
// x0 hardwired to zero and same-cycle write-through on reads.
module register_file
  import rv32i_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [31:1];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o =
    (raddr1_i == 5'd0) ? 32'h0 :
    (wr_en && waddr_i == raddr1_i) ? wdata_i :
    regs_q[raddr1_i];

  assign rdata2_o =
    (raddr2_i == 5'd0) ? 32'h0 :
    (wr_en && waddr_i == raddr2_i) ? wdata_i :
    regs_q[raddr2_i];

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control/immediate generation, register
// read, load-use hazard detection and the ID/EX register.
module decode_cycle
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode_IF,
  input  logic [31:0] PCOutData_IF,
  input  logic [31:0] PC_4_AdderResult_IF,
  input  logic        regWriteEn_WB,
  input  logic [4:0]  rd_WB,
  input  logic [31:0] wdata_WB,
  input  logic        flush_ID,
  output logic        stall,
  output logic        PCEn,
  output logic [31:0] rs1Data_ID,
  output logic [31:0] rs2Data_ID,
  output logic [31:0] imm_ID,
  output logic [4:0]  rs1_ID,
  output logic [4:0]  rs2_ID,
  output logic [4:0]  rd_ID,
  output logic [2:0]  funct3_ID,
  output logic [3:0]  aluCtrl_ID,
  output logic        regWrite_ID,
  output logic        memRead_ID,
  output logic        memWrite_ID,
  output logic        branch_ID,
  output logic        jal_ID,
  output logic        jalr_ID,
  output logic        aluSrc_ID,
  output logic [1:0]  wbSel_ID,
  output logic [31:0] PCOutData_ID,
  output logic [31:0] PC_4_ID
);

  // Zero control decodes as ALU_ADD / WB_ALU.
  localparam id_ex_t BUBBLE = id_ex_t'({
    {($bits(id_ex_t) - 64){1'b0}}, RESET_PC, 32'h0
  });

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        f7b5;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rdata1, rdata2;

  assign ins  = instrCode_IF;
  assign opc  = ins[6:0];
  assign rd   = ins[11:7];
  assign f3   = ins[14:12];
  assign rs1  = ins[19:15];
  assign rs2  = ins[24:20];
  assign f7b5 = ins[30];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  register_file u_rf (
    .clk_i    (clk),
    .rst_ni   (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (regWriteEn_WB),
    .waddr_i  (rd_WB),
    .wdata_i  (wdata_WB)
  );

  alu_ctrl_e alu_f3;

  always_comb begin
    unique case (f3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  ctrl_t       ctrl;
  logic [31:0] imm;
  logic [4:0]  rd_dec;
  logic        uses_rs2;

  always_comb begin
    ctrl     = CTRL_NOP;
    imm      = '0;
    rd_dec   = rd;
    uses_rs2 = 1'b0;
    unique case (opc)
      OPC_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASS_B;
        imm            = imm_u;
      end
      OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = imm_u;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        imm            = imm_j;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        imm            = imm_i;
      end
      OPC_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        imm           = imm_b;
        uses_rs2      = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.wb_sel    = WB_MEM;
        imm            = imm_i;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm            = imm_s;
        uses_rs2       = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // funct7[5] of ADDI is immediate data, not SUB.
        ctrl.alu_ctrl  = (f3 == 3'b000) ? ALU_ADD : alu_f3;
        imm            = imm_i;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = (f3 == 3'b000 && f7b5) ? ALU_SUB : alu_f3;
        uses_rs2       = 1'b1;
      end
      default: rd_dec = '0;
    endcase
  end

  id_ex_t idex_d, idex_q;
  id_ex_t dec;
  logic   load_use;

  always_comb begin
    dec          = BUBBLE;
    dec.ctrl     = ctrl;
    dec.rs1_data = rdata1;
    dec.rs2_data = rdata2;
    dec.imm      = imm;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd_dec;
    dec.funct3   = f3;
    dec.pc       = PCOutData_IF;
    dec.pc4      = PC_4_AdderResult_IF;
  end

  assign load_use = idex_q.ctrl.mem_read
                 && (idex_q.rd != 5'd0)
                 && ((idex_q.rd == rs1)
                  || (uses_rs2 && idex_q.rd == rs2));

  assign stall = load_use & ~flush_ID;
  assign PCEn  = ~stall;

  always_comb begin
    if (flush_ID || load_use) idex_d = BUBBLE;
    else                      idex_d = dec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= BUBBLE;
    else        idex_q <= idex_d;
  end

  assign rs1Data_ID   = idex_q.rs1_data;
  assign rs2Data_ID   = idex_q.rs2_data;
  assign imm_ID       = idex_q.imm;
  assign rs1_ID       = idex_q.rs1;
  assign rs2_ID       = idex_q.rs2;
  assign rd_ID        = idex_q.rd;
  assign funct3_ID    = idex_q.funct3;
  assign aluCtrl_ID   = idex_q.ctrl.alu_ctrl;
  assign regWrite_ID  = idex_q.ctrl.reg_write;
  assign memRead_ID   = idex_q.ctrl.mem_read;
  assign memWrite_ID  = idex_q.ctrl.mem_write;
  assign branch_ID    = idex_q.ctrl.branch;
  assign jal_ID       = idex_q.ctrl.jal;
  assign jalr_ID      = idex_q.ctrl.jalr;
  assign aluSrc_ID    = idex_q.ctrl.alu_src;
  assign wbSel_ID     = idex_q.ctrl.wb_sel;
  assign PCOutData_ID = idex_q.pc;
  assign PC_4_ID      = idex_q.pc4;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed cases then random instruction
// streams checked against an ISA-level model of the stage.
module tb_decode_cycle;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3;
  localparam int A_SLTU = 4, A_XOR = 5, A_SRL = 6, A_SRA = 7;
  localparam int A_OR = 8, A_AND = 9, A_PASSB = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode_IF, PCOutData_IF, PC_4_AdderResult_IF;
  logic        regWriteEn_WB;
  logic [4:0]  rd_WB;
  logic [31:0] wdata_WB;
  logic        flush_ID;
  logic        stall, PCEn;
  logic [31:0] rs1Data_ID, rs2Data_ID, imm_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID;
  logic [2:0]  funct3_ID;
  logic [3:0]  aluCtrl_ID;
  logic        regWrite_ID, memRead_ID, memWrite_ID;
  logic        branch_ID, jal_ID, jalr_ID, aluSrc_ID;
  logic [1:0]  wbSel_ID;
  logic [31:0] PCOutData_ID, PC_4_ID;

  decode_cycle #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .instrCode_IF(instrCode_IF),
    .PCOutData_IF(PCOutData_IF),
    .PC_4_AdderResult_IF(PC_4_AdderResult_IF),
    .regWriteEn_WB(regWriteEn_WB), .rd_WB(rd_WB),
    .wdata_WB(wdata_WB), .flush_ID(flush_ID),
    .stall(stall), .PCEn(PCEn),
    .rs1Data_ID(rs1Data_ID), .rs2Data_ID(rs2Data_ID),
    .imm_ID(imm_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rd_ID(rd_ID), .funct3_ID(funct3_ID),
    .aluCtrl_ID(aluCtrl_ID), .regWrite_ID(regWrite_ID),
    .memRead_ID(memRead_ID), .memWrite_ID(memWrite_ID),
    .branch_ID(branch_ID), .jal_ID(jal_ID),
    .jalr_ID(jalr_ID), .aluSrc_ID(aluSrc_ID),
    .wbSel_ID(wbSel_ID), .PCOutData_ID(PCOutData_ID),
    .PC_4_ID(PC_4_ID)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1d, rs2d, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [1:0]  wb;
    logic rw, mr, mw, br, jal, jalr, src;
  } exp_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] mreg [32];
  exp_t        cur;
  logic        obs_stall;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble_exp();
    exp_t e;
    e.rs1d = 0; e.rs2d = 0; e.imm = 0; e.pc = RPC; e.pc4 = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.f3 = 0;
    e.alu = A_ADD; e.wb = 0;
    e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0;
    e.jal = 0; e.jalr = 0; e.src = 0;
    return e;
  endfunction

  function automatic logic [3:0] alu_of(logic [2:0] f3,
                                        logic b30, logic is_op);
    logic [3:0] tbl [8];
    tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (f3 == 3'd5 && b30) return A_SRA;
    if (is_op && f3 == 3'd0 && b30) return A_SUB;
    return tbl[f3];
  endfunction

  function automatic logic [31:0] mread(logic [4:0] a, logic we,
                                        logic [4:0] wa, logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa != 0 && wa == a) return wd;
    return mreg[a];
  endfunction

  function automatic exp_t model(logic [31:0] i, logic [31:0] pc,
                                 logic [31:0] rd1, logic [31:0] rd2);
    exp_t e;
    logic [31:0] ii, is, ib, iu, ij;
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iu = {i[31:12], 12'b0};
    ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = bubble_exp();
    e.pc = pc; e.pc4 = pc + 4;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12];
    e.rs1d = rd1; e.rs2d = rd2; e.rd = i[11:7];
    case (i[6:0])
      7'h37: begin e.rw = 1; e.src = 1; e.alu = A_PASSB; e.imm = iu; end
      7'h17: begin e.rw = 1; e.src = 1; e.imm = iu; end
      7'h6F: begin e.rw = 1; e.jal = 1; e.src = 1; e.wb = 2; e.imm = ij; end
      7'h67: begin e.rw = 1; e.jalr = 1; e.src = 1; e.wb = 2; e.imm = ii; end
      7'h63: begin e.br = 1; e.alu = A_SUB; e.imm = ib; end
      7'h03: begin e.rw = 1; e.mr = 1; e.src = 1; e.wb = 1; e.imm = ii; end
      7'h23: begin e.mw = 1; e.src = 1; e.imm = is; end
      7'h13: begin
        e.rw = 1; e.src = 1; e.imm = ii;
        e.alu = alu_of(i[14:12], i[30], 1'b0);
      end
      7'h33: begin e.rw = 1; e.alu = alu_of(i[14:12], i[30], 1'b1); end
      default: e.rd = 0;
    endcase
    return e;
  endfunction

  task automatic check_all();
    chk("rs1Data", rs1Data_ID, cur.rs1d);
    chk("rs2Data", rs2Data_ID, cur.rs2d);
    chk("imm", imm_ID, cur.imm);
    chk("rs1", rs1_ID, cur.rs1);
    chk("rs2", rs2_ID, cur.rs2);
    chk("rd", rd_ID, cur.rd);
    chk("funct3", funct3_ID, cur.f3);
    chk("aluCtrl", aluCtrl_ID, cur.alu);
    chk("regWrite", regWrite_ID, cur.rw);
    chk("memRead", memRead_ID, cur.mr);
    chk("memWrite", memWrite_ID, cur.mw);
    chk("branch", branch_ID, cur.br);
    chk("jal", jal_ID, cur.jal);
    chk("jalr", jalr_ID, cur.jalr);
    chk("aluSrc", aluSrc_ID, cur.src);
    chk("wbSel", wbSel_ID, cur.wb);
    chk("PCOut", PCOutData_ID, cur.pc);
    chk("PC4", PC_4_ID, cur.pc4);
  endtask

  task automatic step(input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    logic lu;
    logic [4:0] h;
    logic rd2;
    exp_t nx;
    instrCode_IF = ins;
    PCOutData_IF = pc_ctr;
    PC_4_AdderResult_IF = pc_ctr + 4;
    flush_ID = fl;
    regWriteEn_WB = we;
    rd_WB = wa;
    wdata_WB = wd;
    #1;
    h = cur.rd;
    rd2 = (ins[6:0] == 7'h63) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h33);
    lu = cur.mr && h != 0 && (h == ins[19:15] || (rd2 && h == ins[24:20]));
    obs_stall = stall;
    chk("stall", stall, lu && !fl);
    chk("PCEn", PCEn, !(lu && !fl));
    if (fl || lu) nx = bubble_exp();
    else nx = model(ins, pc_ctr, mread(ins[19:15], we, wa, wd),
                    mread(ins[24:20], we, wa, wd));
    @(posedge clk);
    #1;
    if (we && wa != 0) mreg[wa] = wd;
    cur = nx;
    check_all();
    if (!(lu && !fl)) pc_ctr = pc_ctr + 4;
    if (fl) pc_ctr = {$urandom_range(0, 255), 2'b00};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) mreg[r] = 0;
    cur = bubble_exp();
    check_all();
    reset = 1'b1;
    regWriteEn_WB = 1'b0;
    flush_ID = 1'b0;
    instrCode_IF = 32'h0;
    #1;
    check_all();
    chk("rst_stall", stall, 1'b0);
    chk("rst_PCEn", PCEn, 1'b1);
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] s2,
      logic [4:0] s1, logic [2:0] f3, logic [4:0] d, logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] s1,
      logic [2:0] f3, logic [4:0] d, logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] b, logic [4:0] s2,
      logic [4:0] s1, logic [2:0] f3);
    return {b[12], b[10:5], s2, s1, f3, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(logic [20:0] j, logic [4:0] d);
    return {j[20], j[10:1], j[11], j[19:12], d, 7'h6F};
  endfunction

  logic [6:0]  opcs [11];
  logic [31:0] rins;

  initial begin
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
             7'h23, 7'h13, 7'h33, 7'h7F, 7'h00};
    instrCode_IF = 0; PCOutData_IF = 0; PC_4_AdderResult_IF = 0;
    regWriteEn_WB = 0; rd_WB = 0; wdata_WB = 0; flush_ID = 0;
    cur = bubble_exp();
    do_reset();

    for (int r = 1; r < 32; r++)
      step(enc_r(7'h00, r[4:0], r[4:0], 3'd0, 5'd0, 7'h33), 0, 0, 0, 0);

    step(enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6, 7'h33),
         0, 1, 5'd5, 32'hDEAD_BEEF);
    chk("byp_rs1Data", rs1Data_ID, 32'hDEAD_BEEF);
    chk("byp_alu", aluCtrl_ID, A_ADD);
    chk("byp_regWrite", regWrite_ID, 1'b1);

    step(enc_i(12'd0, 5'd1, 3'd2, 5'd7, 7'h03), 0, 0, 0, 0);
    step(enc_r(7'h20, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33), 0, 0, 0, 0);
    chk("lu_stall", obs_stall, 1'b1);
    chk("lu_bubble_rd", rd_ID, 5'd0);
    step(enc_r(7'h20, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33), 0, 0, 0, 0);
    chk("lu_release", obs_stall, 1'b0);
    chk("sub_alu", aluCtrl_ID, A_SUB);
    chk("sub_rd", rd_ID, 5'd8);

    step(enc_i(12'd0, 5'd1, 3'd2, 5'd7, 7'h03), 0, 0, 0, 0);
    step(enc_r(7'h20, 5'd2, 5'd7, 3'd0, 5'd8, 7'h33), 1, 0, 0, 0);
    chk("fl_stall", obs_stall, 1'b0);
    chk("fl_regWrite", regWrite_ID, 1'b0);
    chk("fl_pc", PCOutData_ID, RPC);

    step(enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0), 0, 0, 0, 0);
    chk("beq_imm", imm_ID, 32'hFFFF_FFFC);
    chk("beq_branch", branch_ID, 1'b1);
    step(enc_j(21'd2048, 5'd1), 0, 0, 0, 0);
    chk("jal_imm", imm_ID, 32'h0000_0800);
    chk("jal_wbSel", wbSel_ID, 2'd2);
    step({20'h12345, 5'd3, 7'h37}, 0, 0, 0, 0);
    chk("lui_imm", imm_ID, 32'h1234_5000);
    chk("lui_alu", aluCtrl_ID, A_PASSB);

    step(32'h0000_7F7F, 0, 1, 5'd0, 32'h1);
    chk("unk_regWrite", regWrite_ID, 1'b0);
    chk("unk_rd", rd_ID, 5'd0);
    chk("x0_read", rs1Data_ID, 32'h0);
    step(32'h0, 0, 0, 0, 0);
    chk("zero_rd", rd_ID, 5'd0);

    step(enc_i(12'd5, 5'd0, 3'd0, 5'd9, 7'h13), 0, 1, 5'd9, 32'h55AA);
    regWriteEn_WB = 1; rd_WB = 5'd9; wdata_WB = 32'h1234_0000;
    do_reset();
    step(enc_r(7'h00, 5'd9, 5'd9, 3'd0, 5'd0, 7'h33), 0, 0, 0, 0);
    chk("midrst_x9", rs1Data_ID, 32'h0);

    rins = 0;
    for (int n = 0; n < 400; n++) begin
      if (!obs_stall || flush_ID) begin
        rins = $urandom;
        rins[19:15] = 5'($urandom_range(0, 7));
        rins[24:20] = 5'($urandom_range(0, 7));
        rins[11:7]  = 5'($urandom_range(0, 7));
        rins[6:0]   = opcs[$urandom_range(0, 10)];
      end
      step(rins, $urandom_range(0, 9) == 0, 1'($urandom),
           5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
